// File: rtl/em_mac_sched_if.sv
// Requester handshake bundle for the MAC scheduler.
// One instance per requester; the scheduler sits on the slave side.
interface em_mac_sched_if #(
    parameter int ACCW = 2
);
    logic            VALID;
    logic            READY;
    logic [1:0]      OP;
    logic [ACCW-1:0] ACC;
    logic            FRAC;
    logic            RND;

    modport master (
        output VALID, OP, ACC, FRAC, RND,
        input  READY
    );

    modport slave (
        input  VALID, OP, ACC, FRAC, RND,
        output READY
    );
endinterface

// File: rtl/em_mac_sched.sv
// Two-requester arbiter and M/E/W sequencer for the EU MAC datapath.
// No forwarding: MAC/MSU wait until their accumulator leaves W.
module em_mac_sched #(
    parameter int NACC       = 4,
    parameter int ACCW       = $clog2(NACC),
    parameter int STARVE_LIM = 4
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            HOLD,
    em_mac_sched_if.slave   R0,
    em_mac_sched_if.slave   R1,
    input  logic            CFG_WE,
    input  logic            CFG_BIASRND,
    output logic            VALID_M,
    output logic            OPSEL_M,
    output logic [ACCW-1:0] ACCRD_M,
    output logic            VALID_E,
    output logic            SUB_E,
    output logic            FracMode_E,
    output logic            rnd_E,
    output logic            mzero_E,
    output logic            BIASRND,
    output logic            ACC_WE_W,
    output logic [ACCW-1:0] ACC_WA_W,
    output logic            RSP_VALID_W,
    output logic            RSP_ID_W
);

    typedef enum logic [1:0] {
        OP_MUL = 2'd0,
        OP_MAC = 2'd1,
        OP_MSU = 2'd2,
        OP_CLR = 2'd3
    } op_e;

    typedef struct packed {
        logic            valid;
        logic            id;
        op_e             op;
        logic [ACCW-1:0] acc;
        logic            frac;
        logic            rnd;
    } stage_t;

    // W only needs what the write port and response use.
    typedef struct packed {
        logic            valid;
        logic            id;
        logic [ACCW-1:0] acc;
    } wb_t;

    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    stage_t m_q, m_d;
    stage_t e_q, e_d;
    wb_t    w_q, w_d;
    stage_t iss;

    logic [3:0] starve_q, starve_d;
    logic       bias_q, bias_d;

    logic hz0, hz1;
    logic cand0, cand1;
    logic gnt0, gnt1;
    logic r1_pri;

    function automatic logic acc_busy(
        input logic [ACCW-1:0] a,
        input stage_t          m,
        input stage_t          e,
        input wb_t             w
    );
        return (m.valid && m.acc == a) ||
               (e.valid && e.acc == a) ||
               (w.valid && w.acc == a);
    endfunction

    // Hazard screen and fixed/starvation priority grant.
    always_comb begin
        hz0    = 1'b0;
        hz1    = 1'b0;
        if (R0.OP == OP_MAC || R0.OP == OP_MSU)
            hz0 = acc_busy(R0.ACC, m_q, e_q, w_q);
        if (R1.OP == OP_MAC || R1.OP == OP_MSU)
            hz1 = acc_busy(R1.ACC, m_q, e_q, w_q);
        cand0  = RST_N & ~HOLD & R0.VALID & ~hz0;
        cand1  = RST_N & ~HOLD & R1.VALID & ~hz1;
        r1_pri = (starve_q == LIM);
        gnt0   = cand0 & ~(r1_pri & cand1);
        gnt1   = cand1 & ~(cand0 & ~r1_pri);
    end

    assign R0.READY = gnt0;
    assign R1.READY = gnt1;

    // Bundle for the op entering M; all-zero when nothing issues.
    always_comb begin
        iss = '0;
        unique case (1'b1)
            gnt0: begin
                iss.valid = 1'b1;
                iss.id    = 1'b0;
                iss.op    = op_e'(R0.OP);
                iss.acc   = R0.ACC;
                iss.frac  = R0.FRAC;
                iss.rnd   = R0.RND;
            end
            gnt1: begin
                iss.valid = 1'b1;
                iss.id    = 1'b1;
                iss.op    = op_e'(R1.OP);
                iss.acc   = R1.ACC;
                iss.frac  = R1.FRAC;
                iss.rnd   = R1.RND;
            end
            default: iss = '0;
        endcase
    end

    // Stage advance, frozen as a whole while HOLD is high.
    always_comb begin
        m_d = m_q;
        e_d = e_q;
        w_d = w_q;
        if (!HOLD) begin
            m_d       = iss;
            e_d       = m_q;
            w_d.valid = e_q.valid;
            w_d.id    = e_q.id;
            w_d.acc   = e_q.acc;
        end
    end

    // Starvation counter: counts R1 losses, cleared on grant or idle.
    always_comb begin
        starve_d = starve_q;
        if (!HOLD) begin
            if (!R1.VALID || gnt1)
                starve_d = 4'd0;
            else if (starve_q < LIM)
                starve_d = starve_q + 4'd1;
        end
    end

    // Config register loads even while the pipe is held.
    always_comb begin
        bias_d = bias_q;
        if (CFG_WE)
            bias_d = CFG_BIASRND;
    end

    // State registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_q      <= '0;
            e_q      <= '0;
            w_q      <= '0;
            starve_q <= 4'd0;
            bias_q   <= 1'b0;
        end else begin
            m_q      <= m_d;
            e_q      <= e_d;
            w_q      <= w_d;
            starve_q <= starve_d;
            bias_q   <= bias_d;
        end
    end

    // Stage decode; every control is qualified by its stage valid.
    always_comb begin
        VALID_M     = m_q.valid;
        OPSEL_M     = m_q.valid & m_q.id;
        ACCRD_M     = m_q.valid ? m_q.acc : '0;
        VALID_E     = e_q.valid;
        SUB_E       = e_q.valid & (e_q.op == OP_MSU);
        mzero_E     = e_q.valid & (e_q.op == OP_CLR);
        FracMode_E  = e_q.valid & e_q.frac;
        rnd_E       = e_q.valid & e_q.rnd;
        ACC_WE_W    = w_q.valid;
        RSP_VALID_W = w_q.valid;
        ACC_WA_W    = w_q.valid ? w_q.acc : '0;
        RSP_ID_W    = w_q.valid & w_q.id;
        BIASRND     = bias_q;
    end

endmodule

// File: tb/tb_em_mac_sched.sv
// Directed self-checking bench for em_mac_sched.
// Expected values are hand-derived cycle tables.
module tb_em_mac_sched;

    localparam int ACCW = 2;

    localparam logic [1:0] MUL = 2'd0;
    localparam logic [1:0] MAC = 2'd1;
    localparam logic [1:0] MSU = 2'd2;
    localparam logic [1:0] CLR = 2'd3;

    logic            CLK = 1'b0;
    logic            RST_N;
    logic            HOLD;
    logic            CFG_WE;
    logic            CFG_BIASRND;
    logic            VALID_M;
    logic            OPSEL_M;
    logic [ACCW-1:0] ACCRD_M;
    logic            VALID_E;
    logic            SUB_E;
    logic            FracMode_E;
    logic            rnd_E;
    logic            mzero_E;
    logic            BIASRND;
    logic            ACC_WE_W;
    logic [ACCW-1:0] ACC_WA_W;
    logic            RSP_VALID_W;
    logic            RSP_ID_W;

    em_mac_sched_if #(.ACCW(ACCW)) r0_if ();
    em_mac_sched_if #(.ACCW(ACCW)) r1_if ();

    em_mac_sched #(
        .NACC       (4),
        .ACCW       (ACCW),
        .STARVE_LIM (4)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .HOLD        (HOLD),
        .R0          (r0_if),
        .R1          (r1_if),
        .CFG_WE      (CFG_WE),
        .CFG_BIASRND (CFG_BIASRND),
        .VALID_M     (VALID_M),
        .OPSEL_M     (OPSEL_M),
        .ACCRD_M     (ACCRD_M),
        .VALID_E     (VALID_E),
        .SUB_E       (SUB_E),
        .FracMode_E  (FracMode_E),
        .rnd_E       (rnd_E),
        .mzero_E     (mzero_E),
        .BIASRND     (BIASRND),
        .ACC_WE_W    (ACC_WE_W),
        .ACC_WA_W    (ACC_WA_W),
        .RSP_VALID_W (RSP_VALID_W),
        .RSP_ID_W    (RSP_ID_W)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        HOLD          = 1'b0;
        CFG_WE        = 1'b0;
        CFG_BIASRND   = 1'b0;
        r0_if.VALID   = 1'b0;
        r0_if.OP      = MUL;
        r0_if.ACC     = '0;
        r0_if.FRAC    = 1'b0;
        r0_if.RND     = 1'b0;
        r1_if.VALID   = 1'b0;
        r1_if.OP      = MUL;
        r1_if.ACC     = '0;
        r1_if.FRAC    = 1'b0;
        r1_if.RND     = 1'b0;
    endtask

    task automatic drain();
        idle();
        repeat (4) step();
    endtask

    logic [31:0] mask0, mask1, subm;
    int          both;
    int          rsp_cnt;
    logic        msu_done;

    initial begin
        idle();
        RST_N = 1'b0;
        #1;
        r0_if.VALID = 1'b1;
        #1;
        check("rst_ready", {31'd0, r0_if.READY}, 32'd0);
        r0_if.VALID = 1'b0;
        repeat (2) step();
        check("rst_outs",
              {VALID_M, VALID_E, ACC_WE_W, RSP_VALID_W, BIASRND},
              32'd0);
        RST_N = 1'b1;
        step();

        // Single MAC walk through M/E/W.
        r0_if.VALID = 1'b1;
        r0_if.OP    = MAC;
        r0_if.ACC   = 2'd1;
        r0_if.FRAC  = 1'b1;
        r0_if.RND   = 1'b1;
        #1;
        check("t1_grant", {r0_if.READY, r1_if.READY}, 32'b10);
        step();
        idle();
        #1;
        check("t1_m", {VALID_M, OPSEL_M, ACCRD_M, VALID_E},
              32'b1_0_01_0);
        step();
        check("t1_e",
              {VALID_M, VALID_E, FracMode_E, rnd_E, SUB_E, mzero_E,
               ACC_WE_W},
              32'b0_1_1_1_0_0_0);
        step();
        check("t1_w",
              {VALID_E, FracMode_E, rnd_E, ACC_WE_W, RSP_VALID_W,
               ACC_WA_W, RSP_ID_W},
              32'b0_0_0_1_1_01_0);
        step();
        check("t1_after", {ACC_WE_W, RSP_VALID_W, VALID_E}, 32'd0);
        drain();

        // Dependent MAC stream: one grant every four cycles.
        mask0 = '0;
        for (int i = 0; i < 9; i++) begin
            r0_if.VALID = 1'b1;
            r0_if.OP    = MAC;
            r0_if.ACC   = 2'd2;
            #1;
            mask0[i] = r0_if.READY;
            step();
        end
        check("t2_mac_grants", mask0, 32'h111);
        drain();

        // Independent MUL stream: one grant per cycle.
        mask0 = '0;
        for (int i = 0; i < 4; i++) begin
            r0_if.VALID = 1'b1;
            r0_if.OP    = MUL;
            r0_if.ACC   = 2'd2;
            #1;
            mask0[i] = r0_if.READY;
            step();
        end
        check("t2_mul_grants", mask0, 32'hF);
        drain();

        // Both requesting: R1 promoted after four losses.
        mask0 = '0;
        mask1 = '0;
        both  = 0;
        for (int i = 0; i < 10; i++) begin
            r0_if.VALID = 1'b1;
            r0_if.OP    = MUL;
            r0_if.ACC   = 2'(i);
            r1_if.VALID = 1'b1;
            r1_if.OP    = MUL;
            r1_if.ACC   = 2'(i + 1);
            #1;
            mask0[i] = r0_if.READY;
            mask1[i] = r1_if.READY;
            if (r0_if.READY && r1_if.READY)
                both++;
            step();
        end
        check("t3_r0_grants", mask0, 32'h1EF);
        check("t3_r1_grants", mask1, 32'h210);
        check("t3_onehot", both, 32'd0);
        drain();

        // Hazarded R0 MSU does not block a clean R1 MUL.
        mask0    = '0;
        subm     = '0;
        msu_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            r0_if.VALID = (i == 0) || !msu_done;
            r0_if.OP    = (i == 0) ? MAC : MSU;
            r0_if.ACC   = 2'd0;
            r1_if.VALID = (i == 1);
            r1_if.OP    = MUL;
            r1_if.ACC   = 2'd3;
            #1;
            if (i == 1)
                check("t4_r1_wins", {r0_if.READY, r1_if.READY}, 32'b01);
            if (i == 4)
                check("t4_r1_rsp",
                      {RSP_VALID_W, RSP_ID_W, ACC_WA_W}, 32'b1_1_11);
            mask0[i] = r0_if.READY;
            if (i > 0 && r0_if.READY)
                msu_done = 1'b1;
            subm[i] = SUB_E;
            step();
        end
        check("t4_r0_grants", mask0, 32'h11);
        check("t4_sub_e", subm, 32'h40);
        drain();

        // CLR, HOLD with an op in E, config load under HOLD.
        r0_if.VALID = 1'b1;
        r0_if.OP    = CLR;
        r0_if.ACC   = 2'd1;
        #1;
        check("t5_clr_grant", {31'd0, r0_if.READY}, 32'd1);
        step();
        idle();
        step();
        check("t5_mzero", {VALID_E, mzero_E, SUB_E}, 32'b110);
        HOLD        = 1'b1;
        r1_if.VALID = 1'b1;
        r1_if.OP    = MUL;
        r1_if.ACC   = 2'd2;
        #1;
        check("t5_hold_nogrant", {31'd0, r1_if.READY}, 32'd0);
        step();
        CFG_WE      = 1'b1;
        CFG_BIASRND = 1'b1;
        #1;
        check("t5_hold_e", {VALID_E, mzero_E, ACC_WE_W}, 32'b110);
        check("t5_bias_old", {31'd0, BIASRND}, 32'd0);
        step();
        HOLD        = 1'b0;
        CFG_WE      = 1'b0;
        CFG_BIASRND = 1'b0;
        r1_if.VALID = 1'b0;
        #1;
        check("t5_bias_new", {31'd0, BIASRND}, 32'd1);
        check("t5_e_after", {VALID_E, mzero_E, ACC_WE_W}, 32'b110);
        step();
        check("t5_w", {ACC_WE_W, ACC_WA_W, VALID_E}, 32'b1_01_0);
        step();
        check("t5_w_done", {31'd0, ACC_WE_W}, 32'd0);
        drain();

        // Reset with M, E and W all occupied.
        for (int i = 0; i < 3; i++) begin
            r0_if.VALID = 1'b1;
            r0_if.OP    = MUL;
            r0_if.ACC   = 2'(i);
            step();
        end
        idle();
        #1;
        check("t6_full", {VALID_M, VALID_E, ACC_WE_W}, 32'b111);
        r0_if.VALID = 1'b1;
        r0_if.ACC   = 2'd3;
        RST_N       = 1'b0;
        #1;
        check("t6_flush",
              {VALID_M, VALID_E, ACC_WE_W, RSP_VALID_W, r0_if.READY},
              32'd0);
        check("t6_bias_rst", {31'd0, BIASRND}, 32'd0);
        step();
        step();
        RST_N       = 1'b1;
        r0_if.ACC   = 2'd1;
        #1;
        check("t6_first_grant", {31'd0, r0_if.READY}, 32'd1);
        step();
        idle();
        rsp_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            if (RSP_VALID_W)
                rsp_cnt++;
            step();
        end
        check("t6_no_stale_rsp", rsp_cnt, 32'd0);
        check("t6_new_rsp", {RSP_VALID_W, ACC_WA_W, RSP_ID_W},
              32'b1_01_0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
